// File: rtl/alu_shift_pkg.sv
// Shared definitions for the iterative shift/rotate engine.
//   - shift mode codes (ALU_FUN[1:0])
//   - operand select codes (ALU_FUN[2])
//   - FSM state encoding
package alu_shift_pkg;

  localparam logic [1:0] MODE_SRL = 2'b00;
  localparam logic [1:0] MODE_SLL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/alu_shift_engine_if.sv
// Operation bus between the ALU decoder and the shift engine.
//   master (decoder): A, B, ALU_FUN, SHAMT, Shift_Enable
//   slave  (engine) : Busy, Shift_OUT, Carry_OUT, OUT_VALID, o_dbg_state
//
// Handshake: an operation is accepted on the rising edge where
// Shift_Enable=1 and Busy=0. Operands are sampled only at that edge.
// Shift_Enable seen while Busy=1 is dropped, not queued. Each accepted
// operation yields exactly one single-cycle OUT_VALID strobe; Shift_OUT
// and Carry_OUT hold until the next strobe. Busy is low again in the
// OUT_VALID cycle, so a new request there is accepted (back-to-back).
interface alu_shift_engine_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int AMT_WIDTH     = $clog2(DATA_WIDTH) + 1,
  parameter int ALU_FUN_WIDTH = 3
);
  import alu_shift_pkg::*;

  logic [DATA_WIDTH-1:0]    A;
  logic [DATA_WIDTH-1:0]    B;
  logic [ALU_FUN_WIDTH-1:0] ALU_FUN;
  logic [AMT_WIDTH-1:0]     SHAMT;
  logic                     Shift_Enable;
  logic                     Busy;
  logic [DATA_WIDTH-1:0]    Shift_OUT;
  logic                     Carry_OUT;
  logic                     OUT_VALID;
  state_t                   o_dbg_state;

  modport master (
    output A, B, ALU_FUN, SHAMT, Shift_Enable,
    input  Busy, Shift_OUT, Carry_OUT, OUT_VALID, o_dbg_state
  );

  modport slave (
    input  A, B, ALU_FUN, SHAMT, Shift_Enable,
    output Busy, Shift_OUT, Carry_OUT, OUT_VALID, o_dbg_state
  );

endinterface

// File: rtl/alu_shift_step.sv
// Combinational single-bit shift/rotate of a DATA_WIDTH word.
//   i_word : current word
//   i_mode : MODE_SRL / MODE_SLL / MODE_SRA / MODE_ROR
//   i_fill : bit entering the vacated end (ignored for ROR)
//   o_word : word after one step
//   o_exit : bit leaving the word on this step
module alu_shift_step
  import alu_shift_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic [1:0]            i_mode,
  input  logic                  i_fill,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_exit
);

  always_comb begin
    o_word = i_word;
    o_exit = 1'b0;
    case (i_mode)
      MODE_SRL, MODE_SRA: begin
        o_word = {i_fill, i_word[DATA_WIDTH-1:1]};
        o_exit = i_word[0];
      end
      MODE_SLL: begin
        o_word = {i_word[DATA_WIDTH-2:0], i_fill};
        o_exit = i_word[DATA_WIDTH-1];
      end
      MODE_ROR: begin
        o_word = {i_word[0], i_word[DATA_WIDTH-1:1]};
        o_exit = i_word[0];
      end
      default: begin
        o_word = i_word;
        o_exit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_shift_engine.sv
// Iterative shift/rotate engine: one bit per clock, four modes, operand
// select, registered result with a one-cycle OUT_VALID strobe.
//   CLK : rising-edge clock
//   RST : asynchronous active-low reset
//   bus : alu_shift_engine_if.slave (operands, request, result, status)
module alu_shift_engine
  import alu_shift_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int AMT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic              CLK,
  input  logic              RST,
  alu_shift_engine_if.slave bus
);

  localparam logic [AMT_WIDTH-1:0] LP_DW  = AMT_WIDTH'(DATA_WIDTH);
  localparam logic [AMT_WIDTH-1:0] LP_ONE = AMT_WIDTH'(1);

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_work;
  logic [AMT_WIDTH-1:0]  r_cnt;
  logic [1:0]            r_mode;
  logic                  r_sign;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_shift_out;
  logic                  r_carry;
  logic                  r_valid;

  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_operand;
  logic [1:0]            w_mode;
  logic [AMT_WIDTH-1:0]  w_n;
  logic                  w_fill;
  logic [DATA_WIDTH-1:0] w_step_word;
  logic                  w_step_exit;

  // In IDLE, Busy is high only while a zero-count result is pending,
  // so IDLE && !Busy is the accept window.
  assign w_accept  = (r_state == IDLE) && !r_busy && bus.Shift_Enable;
  assign w_operand = (bus.ALU_FUN[2] == SEL_B) ? bus.B : bus.A;
  assign w_mode    = bus.ALU_FUN[1:0];

  // Effective count: rotates wrap, shifts saturate at the word width.
  always_comb begin
    w_n = bus.SHAMT;
    if (w_mode == MODE_ROR) begin
      w_n = bus.SHAMT % LP_DW;
    end else if (bus.SHAMT > LP_DW) begin
      w_n = LP_DW;
    end
  end

  // SRA refills with the sign captured at accept; other modes fill 0.
  assign w_fill = (r_mode == MODE_SRA) ? r_sign : 1'b0;

  alu_shift_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .i_word (r_work),
    .i_mode (r_mode),
    .i_fill (w_fill),
    .o_word (w_step_word),
    .o_exit (w_step_exit)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && (w_n != '0)) begin
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == LP_ONE) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_mode      <= MODE_SRL;
      r_sign      <= 1'b0;
      r_busy      <= 1'b0;
      r_shift_out <= '0;
      r_carry     <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_valid <= 1'b0;
      if (w_accept) begin
        r_work <= w_operand;
        r_mode <= w_mode;
        r_sign <= w_operand[DATA_WIDTH-1];
        r_cnt  <= w_n;
        r_busy <= 1'b1;
      end else if ((r_state == IDLE) && r_busy) begin
        // Zero-count operation: pass the operand through unchanged.
        r_shift_out <= r_work;
        r_carry     <= 1'b0;
        r_valid     <= 1'b1;
        r_busy      <= 1'b0;
      end else if (r_state == SHIFT) begin
        r_work <= w_step_word;
        r_cnt  <= r_cnt - LP_ONE;
        if (r_cnt == LP_ONE) begin
          r_shift_out <= w_step_word;
          r_carry     <= w_step_exit;
          r_valid     <= 1'b1;
          r_busy      <= 1'b0;
        end
      end
    end
  end

  assign bus.Busy        = r_busy;
  assign bus.Shift_OUT   = r_shift_out;
  assign bus.Carry_OUT   = r_carry;
  assign bus.OUT_VALID   = r_valid;
  assign bus.o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_shift_engine.sv
// Bench for alu_shift_engine (DATA_WIDTH=8): directed cases from the
// test plan plus randomized back-to-back operations checked against a
// plain-arithmetic reference model through an expected-result queue.
module tb_alu_shift_engine;
  import alu_shift_pkg::*;

  logic CLK;
  logic RST;

  alu_shift_engine_if #(.DATA_WIDTH(8)) bus ();

  alu_shift_engine #(.DATA_WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fails  = 0;

  // scoreboard: {carry, result}
  logic [8:0] exp_q[$];

  // reference model: shift as wide arithmetic, read result and last exit bit
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] fun, input logic [3:0] sh,
                                       output int n);
    logic [7:0]         op;
    logic [15:0]        wide;
    logic signed [15:0] swide;
    logic [7:0]         res;
    logic               cy;
    op = fun[2] ? b : a;
    if (fun[1:0] == 2'b11) n = int'(sh) % 8;
    else n = (int'(sh) > 8) ? 8 : int'(sh);
    case (fun[1:0])
      2'b00: begin wide = {op, 8'h00} >> n; res = wide[15:8]; cy = wide[7]; end
      2'b01: begin wide = {8'h00, op} << n; res = wide[7:0];  cy = wide[8]; end
      2'b10: begin swide = {op, 8'h00}; swide = swide >>> n; res = swide[15:8]; cy = swide[7]; end
      default: begin
        wide = {op, op} >> n; res = wide[7:0];
        cy = (n == 0) ? 1'b0 : res[7];
      end
    endcase
    return {cy, res};
  endfunction

  // driver: call at a negedge; request is presented for one rising edge
  task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] fun, input logic [3:0] sh);
    bus.A = a; bus.B = b; bus.ALU_FUN = fun; bus.SHAMT = sh;
    bus.Shift_Enable = 1'b1;
    @(negedge CLK);
    bus.Shift_Enable = 1'b0;
  endtask

  // waits (bounded) for OUT_VALID; lat = negedges from now, -1 on timeout
  task automatic wait_valid(input int limit, output int lat, output int busy_cycles);
    lat = -1;
    busy_cycles = 0;
    for (int k = 0; k <= limit; k++) begin
      if (k > 0) @(negedge CLK);
      if (bus.OUT_VALID === 1'b1) begin
        lat = k;
        break;
      end
      if (bus.Busy === 1'b1) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++; if (bus.Busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
    n_checks++; if (bus.OUT_VALID !== 1'b0) begin n_fails++; $display("FAIL reset_valid got %b want 0", bus.OUT_VALID); end
    n_checks++; if (bus.Shift_OUT !== 8'h00) begin n_fails++; $display("FAIL reset_out got %h want 00", bus.Shift_OUT); end
    n_checks++; if (bus.Carry_OUT !== 1'b0) begin n_fails++; $display("FAIL reset_carry got %b want 0", bus.Carry_OUT); end
    n_checks++; if (bus.o_dbg_state !== IDLE) begin n_fails++; $display("FAIL reset_state got %0d want %0d", bus.o_dbg_state, IDLE); end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  // one directed operation with full latency/busy/result/strobe checks
  task automatic test_single(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic [2:0] fun, input logic [3:0] sh,
                             input logic [7:0] want_out, input logic want_cy);
    int n, lat, bc, want_lat;
    logic [8:0] e;
    exp_q.push_back(model(a, b, fun, sh, n));
    want_lat = (n > 1) ? n : 1;
    start_op(a, b, fun, sh);
    wait_valid(20, lat, bc);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h000;
    n_checks++; if (lat !== want_lat) begin n_fails++; $display("FAIL %s_latency got %0d want %0d", name, lat, want_lat); end
    n_checks++; if (bc !== want_lat) begin n_fails++; $display("FAIL %s_busy_cycles got %0d want %0d", name, bc, want_lat); end
    n_checks++; if (bus.Shift_OUT !== e[7:0]) begin n_fails++; $display("FAIL %s_out got %h want %h", name, bus.Shift_OUT, e[7:0]); end
    n_checks++; if (bus.Carry_OUT !== e[8]) begin n_fails++; $display("FAIL %s_carry got %b want %b", name, bus.Carry_OUT, e[8]); end
    n_checks++; if (bus.Shift_OUT !== want_out || bus.Carry_OUT !== want_cy) begin
      n_fails++; $display("FAIL %s_plan got %h/%b want %h/%b", name, bus.Shift_OUT, bus.Carry_OUT, want_out, want_cy);
    end
    @(negedge CLK);
    n_checks++; if (bus.OUT_VALID !== 1'b0) begin n_fails++; $display("FAIL %s_pulse_width got %b want 0", name, bus.OUT_VALID); end
    n_checks++; if (bus.Shift_OUT !== e[7:0]) begin n_fails++; $display("FAIL %s_hold got %h want %h", name, bus.Shift_OUT, e[7:0]); end
  endtask

  task automatic test_busy_ignore_back_to_back();
    int n1, n2, lat, bc, extra;
    logic [8:0] e;
    exp_q.push_back(model(8'hF0, 8'h00, 3'b000, 4'd4, n1));
    start_op(8'hF0, 8'h00, 3'b000, 4'd4);
    // conflicting request while busy
    bus.A = 8'hFF; bus.B = 8'hFF; bus.ALU_FUN = 3'b001; bus.SHAMT = 4'd1;
    bus.Shift_Enable = 1'b1;
    repeat (2) @(negedge CLK);
    bus.Shift_Enable = 1'b0;
    wait_valid(20, lat, bc);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h000;
    n_checks++; if (lat !== n1 - 2) begin n_fails++; $display("FAIL ignore_latency got %0d want %0d", lat, n1 - 2); end
    n_checks++; if (bus.Shift_OUT !== e[7:0] || bus.Shift_OUT !== 8'h0F) begin n_fails++; $display("FAIL ignore_out got %h want %h", bus.Shift_OUT, e[7:0]); end
    n_checks++; if (bus.Carry_OUT !== e[8]) begin n_fails++; $display("FAIL ignore_carry got %b want %b", bus.Carry_OUT, e[8]); end
    n_checks++; if (bus.Busy !== 1'b0) begin n_fails++; $display("FAIL b2b_busy_in_valid got %b want 0", bus.Busy); end
    // new request in the OUT_VALID cycle
    exp_q.push_back(model(8'h3C, 8'h00, 3'b001, 4'd2, n2));
    start_op(8'h3C, 8'h00, 3'b001, 4'd2);
    wait_valid(20, lat, bc);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h000;
    n_checks++; if (lat !== n2) begin n_fails++; $display("FAIL b2b_latency got %0d want %0d", lat, n2); end
    n_checks++; if (bus.Shift_OUT !== e[7:0]) begin n_fails++; $display("FAIL b2b_out got %h want %h", bus.Shift_OUT, e[7:0]); end
    n_checks++; if (bus.Carry_OUT !== e[8]) begin n_fails++; $display("FAIL b2b_carry got %b want %b", bus.Carry_OUT, e[8]); end
    extra = 0;
    repeat (6) begin
      @(negedge CLK);
      if (bus.OUT_VALID === 1'b1) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fails++; $display("FAIL ignore_extra_valid got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid_op();
    int n, lat, bc, seen;
    logic [8:0] e;
    start_op(8'hC3, 8'h00, 3'b000, 4'd5);
    repeat (2) @(negedge CLK);
    n_checks++; if (bus.Busy !== 1'b1) begin n_fails++; $display("FAIL midrst_busy_before got %b want 1", bus.Busy); end
    RST = 1'b0;
    #1;
    n_checks++; if (bus.Busy !== 1'b0) begin n_fails++; $display("FAIL midrst_busy got %b want 0", bus.Busy); end
    n_checks++; if (bus.Shift_OUT !== 8'h00) begin n_fails++; $display("FAIL midrst_out got %h want 00", bus.Shift_OUT); end
    n_checks++; if (bus.Carry_OUT !== 1'b0 || bus.OUT_VALID !== 1'b0) begin n_fails++; $display("FAIL midrst_carry_valid got %b/%b want 0/0", bus.Carry_OUT, bus.OUT_VALID); end
    n_checks++; if (bus.o_dbg_state !== IDLE) begin n_fails++; $display("FAIL midrst_state got %0d want %0d", bus.o_dbg_state, IDLE); end
    @(negedge CLK);
    RST = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge CLK);
      if (bus.OUT_VALID === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fails++; $display("FAIL midrst_stray_valid got %0d want 0", seen); end
    exp_q.push_back(model(8'hC3, 8'h00, 3'b010, 4'd5, n));
    start_op(8'hC3, 8'h00, 3'b010, 4'd5);
    wait_valid(20, lat, bc);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h000;
    n_checks++; if (lat !== n) begin n_fails++; $display("FAIL postrst_latency got %0d want %0d", lat, n); end
    n_checks++; if (bus.Shift_OUT !== e[7:0] || bus.Carry_OUT !== e[8]) begin
      n_fails++; $display("FAIL postrst_result got %h/%b want %h/%b", bus.Shift_OUT, bus.Carry_OUT, e[7:0], e[8]);
    end
    @(negedge CLK);
  endtask

  task automatic test_random();
    int n, lat, bc, want_lat;
    logic [7:0] a, b;
    logic [2:0] fun;
    logic [3:0] sh;
    logic [8:0] e;
    for (int i = 0; i < 40; i++) begin
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      fun = 3'($urandom_range(0, 7));
      sh  = 4'($urandom_range(0, 15));
      exp_q.push_back(model(a, b, fun, sh, n));
      want_lat = (n > 1) ? n : 1;
      start_op(a, b, fun, sh);
      // operand changes after accept must not matter
      bus.A = 8'($urandom_range(0, 255));
      bus.B = 8'($urandom_range(0, 255));
      bus.ALU_FUN = 3'($urandom_range(0, 7));
      bus.SHAMT = 4'($urandom_range(0, 15));
      wait_valid(30, lat, bc);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h000;
      n_checks++; if (lat !== want_lat) begin n_fails++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, want_lat); end
      n_checks++; if (bus.Shift_OUT !== e[7:0]) begin
        n_fails++; $display("FAIL rand%0d_out a=%h b=%h fun=%b sh=%0d got %h want %h", i, a, b, fun, sh, bus.Shift_OUT, e[7:0]);
      end
      n_checks++; if (bus.Carry_OUT !== e[8]) begin
        n_fails++; $display("FAIL rand%0d_carry a=%h b=%h fun=%b sh=%0d got %b want %b", i, a, b, fun, sh, bus.Carry_OUT, e[8]);
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b0;
    bus.A = '0; bus.B = '0; bus.ALU_FUN = '0; bus.SHAMT = '0; bus.Shift_Enable = 1'b0;
    test_reset();
    test_single("sra",      8'h96, 8'h00, 3'b010, 4'd3, 8'hF2, 1'b1);
    test_single("ror_wrap", 8'h00, 8'h81, 3'b111, 4'd9, 8'hC0, 1'b1);
    test_single("sll_sat",  8'h81, 8'h00, 3'b001, 4'd9, 8'h00, 1'b1);
    test_single("zero",     8'h5A, 8'h00, 3'b000, 4'd0, 8'h5A, 1'b0);
    test_single("sra_sat",  8'h80, 8'h00, 3'b010, 4'd15, 8'hFF, 1'b1);
    test_busy_ignore_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
